// File: rtl/picoaes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picoaes_pkg
//  Description : Shared types and constants for the picoAES datapath.
//                - AES_AFFINE_C : AES forward affine constant (8'h63)
//                - nib_pair_t   : GF((2^4)^2) element as {ah, al}
//  Revision    : 1.0 - initial release
// ============================================================================
package picoaes_pkg;

    localparam logic [7:0] AES_AFFINE_C = 8'h63;

    // Composite-field element: ah is the coefficient of x, al the constant term.
    typedef struct packed {
        logic [3:0] ah;
        logic [3:0] al;
    } nib_pair_t;

endpackage : picoaes_pkg
`default_nettype wire

// File: rtl/imap.sv
`default_nettype none
// ============================================================================
//  Module      : imap
//  Description : Combinational inverse isomorphic map GF((2^4)^2) -> GF(2^8).
//                Exact inverse of the forward byte-to-nibble-pair mapping,
//                shared with the key-schedule S-box path.
//  Ports       : pair - nibble pair {ah, al}
//                a    - resulting GF(2^8) byte
//  Revision    : 1.0 - initial release
// ============================================================================
module imap
    import picoaes_pkg::*;
(
    input  nib_pair_t  pair,
    output logic [7:0] a
);

    logic [3:0] w_h;
    logic [3:0] w_l;

    assign w_h = pair.ah;
    assign w_l = pair.al;

    // Pure XOR network; each output bit is a fixed row of the inverse matrix.
    assign a[0] = w_l[0] ^ w_h[0];
    assign a[1] = w_h[0] ^ w_h[1] ^ w_h[3];
    assign a[2] = w_l[1] ^ w_h[0] ^ w_h[1] ^ w_h[3];
    assign a[3] = w_l[1] ^ w_h[0] ^ w_h[1] ^ w_h[2];
    assign a[4] = w_l[1] ^ w_l[3] ^ w_h[0] ^ w_h[1] ^ w_h[3];
    assign a[5] = w_l[2] ^ w_h[0] ^ w_h[1];
    assign a[6] = w_l[1] ^ w_l[2] ^ w_l[3] ^ w_h[0] ^ w_h[3];
    assign a[7] = w_l[2] ^ w_h[0] ^ w_h[1] ^ w_h[3];

endmodule : imap
`default_nettype wire

// File: rtl/imap_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imap_pack
//  Description : Maps composite-field nibble pairs back to GF(2^8) bytes,
//                optionally applies the AES forward affine transform, and
//                packs BYTES bytes into one column word (first byte in MSB).
//  Ports       : clk, rst (async, active-high), clr (sync partial-word clear)
//                in_valid/in_ready/in_ah/in_al/affine_en - byte input side
//                out_valid/out_ready/out_word            - word output side
//  Revision    : 1.0 - initial release
// ============================================================================
module imap_pack
    import picoaes_pkg::*;
#(
    parameter int         BYTES    = 4,
    parameter logic [7:0] AFFINE_C = AES_AFFINE_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_ah,
    input  logic [3:0]           in_al,
    input  logic                 affine_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   out_word
);

    localparam int                 c_CNT_W = $clog2(BYTES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BYTES - 1);

    nib_pair_t                 w_pair;
    logic [7:0]                w_map;
    logic [7:0]                w_byte;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_complete;

    logic [c_CNT_W-1:0]        r_cnt;
    // Holds slots 0..BYTES-2 only; the last slot goes straight to the output.
    logic [8*(BYTES-1)-1:0]    r_asm;
    logic                      r_out_valid;
    logic [8*BYTES-1:0]        r_out_word;

    assign w_pair.ah = in_ah;
    assign w_pair.al = in_al;

    imap u_imap (
        .pair (w_pair),
        .a    (w_map)
    );

    // b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ C_i, written as
    // rotate-right terms so the index wrap is explicit.
    always_comb begin
        w_byte = w_map;
        if (affine_en) begin
            w_byte = w_map
                   ^ {w_map[3:0], w_map[7:4]}
                   ^ {w_map[4:0], w_map[7:5]}
                   ^ {w_map[5:0], w_map[7:6]}
                   ^ {w_map[6:0], w_map[7]}
                   ^ AFFINE_C;
        end
    end

    assign w_last     = (r_cnt == c_LAST);
    // Only the completing byte can stall, and only against a full, held output.
    assign in_ready   = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && !clr && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_asm       <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
        end else begin
            if (clr) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    for (int k = 0; k < BYTES - 1; k++) begin
                        if (r_cnt == c_CNT_W'(k)) begin
                            r_asm[8*(BYTES-2-k) +: 8] <= w_byte;
                        end
                    end
                end
            end

            // A completion takes priority over a drain: the new word replaces
            // the old one and out_valid stays asserted.
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_word  <= {r_asm, w_byte};
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;

endmodule : imap_pack
`default_nettype wire

// File: tb/tb_imap_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imap_pack
//  Description : Self-checking bench for imap_pack (BYTES=4). A byte-queue
//                reference model predicts in_ready, out_valid and out_word
//                every cycle; directed vectors plus randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imap_pack;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_ah;
    logic [3:0]     in_al;
    logic           affine_en;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_word;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [7:0]   mq[$];
    bit         mv;
    bit [W-1:0] mword;
    bit [7:0]   fwd[256];

    always #5 clk = ~clk;

    imap_pack #(.BYTES(BYTES), .AFFINE_C(8'h63)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ah     (in_ah),
        .in_al     (in_al),
        .affine_en (affine_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [7:0] ref_imap(input bit [3:0] h, input bit [3:0] l);
        bit [7:0] a;
        a[0] = l[0] ^ h[0];
        a[1] = h[0] ^ h[1] ^ h[3];
        a[2] = l[1] ^ h[0] ^ h[1] ^ h[3];
        a[3] = l[1] ^ h[0] ^ h[1] ^ h[2];
        a[4] = l[1] ^ l[3] ^ h[0] ^ h[1] ^ h[3];
        a[5] = l[2] ^ h[0] ^ h[1];
        a[6] = l[1] ^ l[2] ^ l[3] ^ h[0] ^ h[3];
        a[7] = l[2] ^ h[0] ^ h[1] ^ h[3];
        return a;
    endfunction

    function automatic bit [7:0] ref_affine(input bit [7:0] a);
        bit [7:0] c = 8'h63;
        bit [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
        return b;
    endfunction

    function automatic bit [W-1:0] pack_q();
        bit [W-1:0] w = '0;
        for (int k = 0; k < BYTES; k++) w = {w[W-9:0], mq[k]};
        return w;
    endfunction

    // One clock cycle: drive on negedge, check in_ready, advance model at
    // posedge, check outputs 1 time unit later.
    task automatic step(input bit v, input bit [3:0] h, input bit [3:0] l,
                        input bit aff, input bit ordy, input bit c);
        bit       rdy;
        bit       done;
        bit [7:0] b;
        done = 1'b0;
        @(negedge clk);
        in_valid = v; in_ah = h; in_al = l; affine_en = aff; out_ready = ordy; clr = c;
        #1;
        rdy = !((mq.size() == BYTES - 1) && mv && !ordy);
        check("in_ready", W'(in_ready), W'(rdy));
        @(posedge clk);
        b = aff ? ref_affine(ref_imap(h, l)) : ref_imap(h, l);
        if (c) begin
            mq.delete();
        end else if (v && rdy) begin
            mq.push_back(b);
            if (mq.size() == BYTES) begin
                mword = pack_q();
                mv    = 1'b1;
                done  = 1'b1;
                mq.delete();
            end
        end
        if (!done && ordy) mv = 1'b0;
        #1;
        check("out_valid", W'(out_valid), W'(mv));
        if (mv) check("out_word", out_word, mword);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ah = '0; in_al = '0;
        affine_en = 1'b0; out_ready = 1'b0;
        mv = 1'b0; mword = '0;

        // Forward map obtained by inverting the reference inverse map.
        for (int h = 0; h < 16; h++)
            for (int l = 0; l < 16; l++)
                fwd[ref_imap(4'(h), 4'(l))] = {4'(h), 4'(l)};

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_word",  out_word,      '0);
        check("rst_in_ready",  W'(in_ready),  W'(1));
        @(negedge clk);
        rst = 1'b0;

        // Inverse-map vectors, affine off
        step(1, 4'h0, 4'h1, 0, 0, 0);
        step(1, 4'h2, 4'h6, 0, 0, 0);
        step(1, 4'hE, 4'h4, 0, 0, 0);
        step(1, 4'h0, 4'h1, 0, 0, 0);
        check("vec_imap", out_word, 32'h0102_8001);

        // Affine vectors, output drained at the same time
        step(1, 4'h0, 4'h0, 1, 1, 0);
        step(1, 4'h0, 4'h1, 1, 0, 0);
        step(1, 4'h0, 4'h0, 1, 0, 0);
        step(1, 4'h0, 4'h1, 1, 0, 0);
        check("vec_affine", out_word, 32'h637C_637C);

        // Backpressure: output held, 4th byte stalls, then replaces on drain
        step(1, 4'h1, 4'h2, 0, 0, 0);
        step(1, 4'h3, 4'h4, 0, 0, 0);
        step(1, 4'h5, 4'h6, 0, 0, 0);
        step(1, 4'h7, 4'h8, 0, 0, 0);
        step(1, 4'h7, 4'h8, 0, 0, 0);
        check("bp_held", out_word, 32'h637C_637C);
        step(1, 4'h7, 4'h8, 0, 1, 0);
        step(0, 4'h0, 4'h0, 0, 1, 0);

        // Sweep every byte through forward map then the DUT
        step(0, 4'h0, 4'h0, 0, 1, 1);
        for (int x = 0; x < 256; x++) begin
            step(1, fwd[x][7:4], fwd[x][3:0], 0, 1, 0);
            if (x % 4 == 3)
                check("sweep_id", out_word, {8'(x-3), 8'(x-2), 8'(x-1), 8'(x)});
        end

        // Continuous streaming, 3 words
        for (int i = 0; i < 12; i++)
            step(1, 4'($urandom), 4'($urandom), 1'($urandom), 1, 0);

        // Clear with a simultaneous byte
        step(1, 4'h0, 4'h1, 0, 1, 0);
        step(1, 4'h2, 4'h6, 0, 1, 0);
        step(1, 4'hE, 4'h4, 0, 1, 1);
        for (int i = 0; i < 4; i++)
            step(1, 4'h0, 4'h0, 1, 1, 0);
        check("clr_word", out_word, 32'h6363_6363);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(3, 0) != 0, 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(31, 0) == 0);

        // Reset mid-word with a held output
        step(0, 4'h0, 4'h0, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            step(1, 4'($urandom), 4'($urandom), 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", W'(out_valid), '0);
        check("arst_out_word",  out_word,      '0);
        check("arst_in_ready",  W'(in_ready),  W'(1));
        mq.delete(); mv = 1'b0; mword = '0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'h0, 4'h1, 0, 0, 0);
        step(1, 4'h2, 4'h6, 0, 0, 0);
        step(1, 4'hE, 4'h4, 0, 0, 0);
        step(1, 4'h0, 4'h0, 1, 0, 0);
        check("post_rst_word", out_word, 32'h0102_8063);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_imap_pack
`default_nettype wire
